// File: rtl/cordic_pkg.sv
// cordic_pkg: shared defaults, direction encoding and FSM state type for the CORDIC vectoring engine
package cordic_pkg;
    localparam int DEF_CORDIC_WIDTH = 22;
    localparam int DEF_N_STAGES = 16;
    localparam logic DIR_CW = 1'b0;
    localparam logic DIR_ACW = 1'b1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} vec_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cordic_vec_engine_if.sv
// cordic_vec_engine_if: input-vector / result handshake bundle of the vectoring engine
interface cordic_vec_engine_if import cordic_pkg::*; #(
    parameter int W = DEF_CORDIC_WIDTH,
    parameter int N = DEF_N_STAGES
);
    logic in_valid, in_ready, out_valid, out_ready, flip_out;
    logic signed [W-1:0] x_in, y_in, x_out, y_out;
    logic [N-1:0] dir_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input in_ready, out_valid, x_out, y_out, dir_out, flip_out
    );
    modport slave (
        input in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, x_out, y_out, dir_out, flip_out
    );
endinterface

// File: rtl/cordic_vec_cell.sv
// cordic_vec_cell: one combinational vectoring micro-rotation toward the +x axis
module cordic_vec_cell import cordic_pkg::*; #(
    parameter int W = DEF_CORDIC_WIDTH,
    parameter int SW = 4
) (
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic [SW-1:0]       shift_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic                dir_o
);
    // rotate against the sign of y; both updates use the old x and y
    always_comb begin
        dir_o = y_i[W-1] ? DIR_ACW : DIR_CW;
        x_o = y_i[W-1] ? x_i - (y_i >>> shift_i) : x_i + (y_i >>> shift_i);
        y_o = y_i[W-1] ? y_i + (x_i >>> shift_i) : y_i - (x_i >>> shift_i);
    end
endmodule

// File: rtl/cordic_vec_engine.sv
// cordic_vec_engine: iterative CORDIC vectoring, one micro-rotation per cycle, emits directions and scaled magnitude
module cordic_vec_engine import cordic_pkg::*; #(
    parameter int CORDIC_WIDTH = DEF_CORDIC_WIDTH,
    parameter int N_STAGES = DEF_N_STAGES
) (
    input logic clk,
    input logic nreset,
    cordic_vec_engine_if.slave io
);
    localparam int CW = cnt_w(N_STAGES);

    vec_state_t state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic signed [CORDIC_WIDTH-1:0] x_q, x_d, y_q, y_d, x_rot, y_rot;
    logic [N_STAGES-1:0] dir_q, dir_d;
    logic flip_q, flip_d, dir_rot;

    cordic_vec_cell #(.W(CORDIC_WIDTH), .SW(CW)) u_cell (
        .x_i(x_q), .y_i(y_q), .shift_i(k_q),
        .x_o(x_rot), .y_o(y_rot), .dir_o(dir_rot)
    );

    // next state: load (pre-rotated by 180 deg when x<0), iterate, then hold the result until taken
    always_comb begin
        state_d = state_q;
        k_d = k_q;
        x_d = x_q;
        y_d = y_q;
        dir_d = dir_q;
        flip_d = flip_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                flip_d = io.x_in[CORDIC_WIDTH-1];
                x_d = flip_d ? -io.x_in : io.x_in;
                y_d = flip_d ? -io.y_in : io.y_in;
                k_d = '0;
                dir_d = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d = x_rot;
                y_d = y_rot;
                dir_d = {dir_rot, dir_q[N_STAGES-1:1]};
                k_d = k_q + CW'(1);
                state_d = (k_q == CW'(N_STAGES - 1)) ? DONE : ITER;
            end
            DONE: state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            k_q <= '0;
            x_q <= '0;
            y_q <= '0;
            dir_q <= '0;
            flip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            x_q <= x_d;
            y_q <= y_d;
            dir_q <= dir_d;
            flip_q <= flip_d;
        end
    end

    assign io.in_ready = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.x_out = x_q;
    assign io.y_out = y_q;
    assign io.dir_out = dir_q;
    assign io.flip_out = flip_q;
endmodule

// File: tb/tb_cordic_vec_engine.sv
// tb_cordic_vec_engine: directed vectors checked against an arithmetic vectoring model plus hand-computed values
module tb_cordic_vec_engine;
    import cordic_pkg::*;

    localparam int W = 22;
    localparam int N = 16;

    typedef struct {
        int x;
        int y;
        logic [N-1:0] d;
        logic f;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    exp_t q[$];
    exp_t e_new, e_ref;
    int n_pass = 0;
    int n_tot = 0;
    int cyc = 0;
    int lat;
    bit armed = 1'b0;
    bit ev;

    cordic_vec_engine_if #(.W(W), .N(N)) bus ();

    cordic_vec_engine #(.CORDIC_WIDTH(W), .N_STAGES(N)) dut (
        .clk(clk),
        .nreset(nreset),
        .io(bus)
    );

    always #5 clk = ~clk;

    // cycle counter used to time results against their accept edge
    always @(posedge clk) cyc <= cyc + 1;

    // vector model: rotate into the right half-plane, then greedily turn toward the +x axis
    function automatic exp_t model(input int xi, input int yi);
        exp_t e;
        int x, y, t;
        e.f = (xi < 0);
        x = e.f ? -xi : xi;
        y = e.f ? -yi : yi;
        e.d = '0;
        for (int k = 0; k < N; k++) begin
            t = x;
            if (y >= 0) begin
                x = x + (y >>> k);
                y = y - (t >>> k);
            end else begin
                e.d[k] = 1'b1;
                x = x - (y >>> k);
                y = y + (t >>> k);
            end
        end
        e.x = x;
        e.y = y;
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int x, input int y);
        bus.in_valid = 1'b1;
        bus.x_in = W'(x);
        bus.y_in = W'(y);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    // replays the emitted directions in the opposite sense on (x_out,0); must land near (0, 1000*K^2)
    task automatic replay_chk();
        int rx, ry, t;
        rx = bus.x_out;
        ry = 0;
        for (int k = 0; k < N; k++) begin
            t = rx;
            if (bus.dir_out[k] == DIR_CW) begin
                rx = rx - (ry >>> k);
                ry = ry + (t >>> k);
            end else begin
                rx = rx + (ry >>> k);
                ry = ry - (t >>> k);
            end
        end
        chk_rng("s3_replay_x", rx, -40, 40);
        chk_rng("s3_replay_y", ry, 2672, 2752);
    endtask

    // scoreboard compare: every cycle checks handshake flags and, while valid, the result fields
    always @(negedge clk) begin
        if (!nreset) q.delete();
        else if (armed) begin
            ev = (q.size() > 0) && (cyc - q[0].acc >= N);
            chk("in_ready", int'(bus.in_ready), int'(q.size() == 0));
            chk("out_valid", int'(bus.out_valid), int'(ev));
            if (ev && bus.out_valid) begin
                chk("x_out", bus.x_out, q[0].x);
                chk("y_out", bus.y_out, q[0].y);
                chk("dir_out", int'(bus.dir_out), int'(q[0].d));
                chk("flip_out", int'(bus.flip_out), int'(q[0].f));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                e_new = model(bus.x_in, bus.y_in);
                e_new.acc = cyc + 1;
                q.push_back(e_new);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.x_in = '0;
        bus.y_in = '0;
        repeat (2) tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_x_out", bus.x_out, 0);
        chk("rst_y_out", bus.y_out, 0);
        chk("rst_dir_out", int'(bus.dir_out), 0);
        chk("rst_flip_out", int'(bus.flip_out), 0);
        nreset = 1'b1;
        armed = 1'b1;

        e_ref = model(1000, 0);
        chk("model_dir10", int'(e_ref.d[1:0]), 2);
        chk_rng("model_x", e_ref.x, 1631, 1663);
        e_new = model(0, 0);
        chk("model_zero", e_new.x + e_new.y + int'(e_new.d), 0);

        send(1000, 0);
        wait_ov(lat);
        chk("s1_latency", lat, 16);
        chk("s1_dir0", int'(bus.dir_out[0]), 0);
        chk("s1_dir1", int'(bus.dir_out[1]), 1);
        chk_rng("s1_x_out", bus.x_out, 1631, 1663);
        chk_rng("s1_y_out", bus.y_out, -16, 16);
        chk("s1_flip", int'(bus.flip_out), 0);
        tick();

        send(-1000, 0);
        wait_ov(lat);
        chk("s2_flip", int'(bus.flip_out), 1);
        chk("s2_dir", int'(bus.dir_out), int'(e_ref.d));
        chk("s2_x_out", bus.x_out, e_ref.x);
        tick();

        send(0, 1000);
        wait_ov(lat);
        chk("s3_dir10", int'(bus.dir_out[1:0]), 0);
        chk_rng("s3_x_out", bus.x_out, 1631, 1663);
        replay_chk();
        tick();

        send(0, 0);
        wait_ov(lat);
        chk("s4_dir", int'(bus.dir_out), 0);
        chk("s4_x_out", bus.x_out, 0);
        chk("s4_y_out", bus.y_out, 0);
        chk("s4_flip", int'(bus.flip_out), 0);
        tick();

        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send(-3000, 4000);
                1: send(300000, -200000);
                2: send(-524288, 524288);
                default: send(17, -524288);
            endcase
            wait_ov(lat);
            tick();
        end

        bus.out_ready = 1'b0;
        send(300, -400);
        wait_ov(lat);
        for (int i = 0; i < 10; i++) begin
            chk("s5_in_ready_held", int'(bus.in_ready), 0);
            bus.in_valid = i[0];
            bus.x_in = W'(5);
            bus.y_in = W'(5);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("s5_release_valid", int'(bus.out_valid), 0);
        chk("s5_release_ready", int'(bus.in_ready), 1);
        send(700, 200);
        wait_ov(lat);
        chk("s5_next_latency", lat, 16);
        tick();

        send(1000, 500);
        repeat (7) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        chk("s6_out_valid", int'(bus.out_valid), 0);
        chk("s6_in_ready", int'(bus.in_ready), 1);
        chk("s6_x_out", bus.x_out, 0);
        chk("s6_y_out", bus.y_out, 0);
        chk("s6_dir_out", int'(bus.dir_out), 0);
        chk("s6_flip_out", int'(bus.flip_out), 0);
        repeat (20) tick();

        send(-250, -900);
        wait_ov(lat);
        chk("s6_recover_latency", lat, 16);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
